bram_port_arbiter: RTL
======================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one BRAM port (ena/wea/addr/din/dout, NB_BRAM_DLY read latency) between two requesters.
//  Per-cycle round-robin or fixed-priority grant; registered port drive; read data routed back by tag.
//  Sits between image-algorithm clients (e.g. line writer, window reader) and port A or B of the BRAM.
// PARAMETERS
//  NB_BRAM_DLY  2   BRAM read latency in clocks (>=1); must match the attached BRAM
//  WD_BRAM_ADR  8   address width
//  WD_BRAM_DAT  32  data width
//  NB_ARB_MODE  0   0 = round-robin, 1 = fixed priority (req0 always wins)
// PORTS
//  i_sys_clk       in   1    single clock for all logic
//  i_sys_rst       in   1    asynchronous active-high reset
//  i_cfg_hold      in   1    1 = issue no grants (in-flight reads still complete)
//  s_req0_vld      in   1    req0 request valid
//  s_req0_rdy      out  1    req0 granted this cycle (handshake = vld & rdy)
//  s_req0_wen      in   1    1 = write, 0 = read
//  s_req0_adr      in   WD_BRAM_ADR  req0 address
//  s_req0_dat      in   WD_BRAM_DAT  req0 write data
//  m_rsp0_vld      out  1    req0 read data valid (1-cycle pulse)
//  m_rsp0_dat      out  WD_BRAM_DAT  req0 read data
//  s_req1_*        -    -    identical set for requester 1 (vld,rdy,wen,adr,dat)
//  m_rsp1_vld/dat  out  -    identical response set for requester 1
//  m_bram_ena      out  1    BRAM port enable (registered)
//  m_bram_wea      out  1    BRAM port write enable (registered)
//  m_bram_addra    out  WD_BRAM_ADR  BRAM address (registered)
//  m_bram_dina     out  WD_BRAM_DAT  BRAM write data (registered)
//  m_bram_douta    in   WD_BRAM_DAT  BRAM read data (valid NB_BRAM_DLY clocks after ena sample)
//  o_busy          out  1    1 while any read is in flight or any port reg is active
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = req1 (so req0 wins first tie); tag pipeline cleared.
//  Grant (combinational): hold=1 -> no rdy. Only one vld -> that one rdy. Both vld: mode 1 -> req0;
//   mode 0 -> requester not granted most recently. Pointer updates only on accepted handshake.
//  At most one rdy per cycle; rdy never asserted without its vld.
//  Issue: handshake at edge N registers ena=1, wea=wen, addr, din -> driven during cycle N..N+1;
//   no handshake -> ena=0, wea=0 next cycle (addr/din hold last value).
//  Read tag: {valid, id} shift register NB_BRAM_DLY deep, loaded at edge N for read handshakes.
//  Response: read accepted at edge N -> m_rspX_vld=1 for exactly one cycle after edge N+NB_BRAM_DLY;
//   m_rspX_dat = m_bram_douta in that cycle (pass-through); other requester's vld stays 0.
//  m_rspX_dat = 0 when m_rspX_vld = 0 (gated).
//  Back-to-back reads from alternating requesters: one response per cycle, in issue order.
//  Writes produce no response; write then read same addr in consecutive grants returns new data.
//  Throughput: one access per clock; no stall on response path (no response backpressure).
//  i_cfg_hold mid-stream: grants stop next cycle, tags drain, o_busy falls NB_BRAM_DLY+1 clocks
//   after last grant.
//  Async reset mid-operation: tags and port regs cleared immediately; in-flight reads never respond.
// TESTING
//  Reset -> all outputs 0, o_busy=0; first tie (both vld) grants req0.
//  req0 write adr 0x10 dat 0xA5A5_0001, then req0 read 0x10 -> m_rsp0 pulse 0xA5A5_0001, 2 clks after read accept.
//  Both vld continuous reads (mode 0) of 0x01/0x02 -> grants alternate 0,1,0,1; responses alternate, no loss.
//  Mode 1, both vld 8 cycles -> req1 never granted; req0 gets 8 grants.
//  i_cfg_hold=1 with reads in flight -> no rdy, pending responses still arrive, o_busy drops after 3 clks.
//  Reset asserted 1 clk after read accept -> no m_rsp pulse, outputs 0 immediately.

Source files
------------

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// bram_port_arbiter: two requesters share one BRAM port; reads routed back by tag
// Rev 1.0
// ============================================================================
module bram_port_arbiter #(
  parameter int NB_BRAM_DLY = 2,
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32,
  parameter int NB_ARB_MODE = 0
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_cfg_hold,
  input  logic                   s_req0_vld,
  output logic                   s_req0_rdy,
  input  logic                   s_req0_wen,
  input  logic [WD_BRAM_ADR-1:0] s_req0_adr,
  input  logic [WD_BRAM_DAT-1:0] s_req0_dat,
  output logic                   m_rsp0_vld,
  output logic [WD_BRAM_DAT-1:0] m_rsp0_dat,
  input  logic                   s_req1_vld,
  output logic                   s_req1_rdy,
  input  logic                   s_req1_wen,
  input  logic [WD_BRAM_ADR-1:0] s_req1_adr,
  input  logic [WD_BRAM_DAT-1:0] s_req1_dat,
  output logic                   m_rsp1_vld,
  output logic [WD_BRAM_DAT-1:0] m_rsp1_dat,
  output logic                   m_bram_ena,
  output logic                   m_bram_wea,
  output logic [WD_BRAM_ADR-1:0] m_bram_addra,
  output logic [WD_BRAM_DAT-1:0] m_bram_dina,
  input  logic [WD_BRAM_DAT-1:0] m_bram_douta,
  output logic                   o_busy
);

  logic                   w_prio0;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_acc;
  logic                   w_wen;
  logic [WD_BRAM_ADR-1:0] w_adr;
  logic [WD_BRAM_DAT-1:0] w_dat;
  logic                   last_d;

  logic                   last_q;
  logic                   ena_q;
  logic                   wea_q;
  logic                   id_q;
  logic [WD_BRAM_ADR-1:0] addr_q;
  logic [WD_BRAM_DAT-1:0] din_q;
  logic [NB_BRAM_DLY-1:0] tag_vld_q;
  logic [NB_BRAM_DLY-1:0] tag_id_q;

  // last_q = 1 means req1 was granted most recently, so req0 wins the next tie
  assign w_prio0 = (NB_ARB_MODE == 1) || !s_req1_vld || last_q;
  assign w_gnt0  = !i_cfg_hold && s_req0_vld && w_prio0;
  assign w_gnt1  = !i_cfg_hold && s_req1_vld && !w_gnt0;
  assign w_acc   = w_gnt0 || w_gnt1;
  assign w_wen   = w_gnt1 ? s_req1_wen : s_req0_wen;
  assign w_adr   = w_gnt1 ? s_req1_adr : s_req0_adr;
  assign w_dat   = w_gnt1 ? s_req1_dat : s_req0_dat;
  assign last_d  = w_acc ? w_gnt1 : last_q;

  assign s_req0_rdy = w_gnt0;
  assign s_req1_rdy = w_gnt1;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      last_q    <= 1'b1;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      id_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      last_q <= last_d;
      ena_q  <= w_acc;
      wea_q  <= w_acc && w_wen;
      if (w_acc) begin
        id_q   <= w_gnt1;
        addr_q <= w_adr;
        din_q  <= w_dat;
      end
      // The port register acts as the first tag stage; the last stage lines up with douta
      tag_vld_q[0] <= ena_q && !wea_q;
      tag_id_q[0]  <= id_q;
      for (int i = 1; i < NB_BRAM_DLY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign m_bram_ena   = ena_q;
  assign m_bram_wea   = wea_q;
  assign m_bram_addra = addr_q;
  assign m_bram_dina  = din_q;

  assign m_rsp0_vld = tag_vld_q[NB_BRAM_DLY-1] && !tag_id_q[NB_BRAM_DLY-1];
  assign m_rsp1_vld = tag_vld_q[NB_BRAM_DLY-1] &&  tag_id_q[NB_BRAM_DLY-1];
  assign m_rsp0_dat = m_rsp0_vld ? m_bram_douta : '0;
  assign m_rsp1_dat = m_rsp1_vld ? m_bram_douta : '0;

  assign o_busy = ena_q || (|tag_vld_q);

endmodule
`default_nettype wire
